// File: rtl/memory_controller.sv
// Byte-serial RAM controller for LSB loads/stores and IF fetches; `IO_STALL_EN holds IO writes while io_buffer_full_in.
// Reads complete n+1 edges after acceptance, writes n edges; LSB takes priority, rollback aborts reads only.
module memory_controller #(
  parameter int         ADDR_WIDTH   = 32,
  parameter logic [1:0] IO_HIGH_BITS = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rollback_in,
  input  logic                  lsb_request_in,
  input  logic                  lsb_rw_in,
  input  logic [ADDR_WIDTH-1:0] lsb_address_in,
  input  logic [2:0]            lsb_goal_in,
  input  logic [31:0]           lsb_data_in,
  output logic                  lsb_ready_out,
  output logic [31:0]           lsb_data_out,
  input  logic                  if_request_in,
  input  logic [ADDR_WIDTH-1:0] if_address_in,
  output logic                  if_ready_out,
  output logic [31:0]           if_data_out,
  output logic [ADDR_WIDTH-1:0] ram_address_out,
  output logic                  ram_rw_out,
  output logic [7:0]            ram_data_out,
  input  logic [7:0]            ram_data_in,
  input  logic                  io_buffer_full_in
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LSB_READ  = 2'd1;
  localparam logic [1:0] LSB_WRITE = 2'd2;
  localparam logic [1:0] IF_READ   = 2'd3;

  logic [1:0]            state;
  logic                  pend_vld, pend_rw;
  logic [ADDR_WIDTH-1:0] pend_addr, base;
  logic [2:0]            pend_goal, goal, cnt;
  logic [31:0]           pend_data, wdata, rdata;

  logic                  rd_state, free, pend_ok, take_lsb, take_if, take_w, stall;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [7:0]            wbyte;
  logic [31:0]           rdata_nxt, wsrc;
  logic [1:0]            widx;
  logic [2:0]            cnt_m1;

  always_comb begin
    rd_state = (state == LSB_READ) || (state == IF_READ);
    free     = (state == IDLE) ||
               ((cnt == goal) && ((state == LSB_WRITE) || (rd_state && !rollback_in)));
    pend_ok  = pend_vld && (pend_rw || !rollback_in);
    take_lsb = free && pend_ok;
    // IF also yields to an LSB pulse landing this edge, so the LSB is served on the next one.
    take_if  = free && !pend_ok && if_request_in && !rollback_in && !lsb_request_in &&
               (state != IF_READ);
    take_w    = take_lsb && pend_rw;
    wsrc      = take_w ? pend_data : wdata;
    widx      = take_w ? 2'd0 : cnt[1:0];
    wbyte     = 8'(wsrc >> {widx, 3'b000});
    waddr     = take_w ? pend_addr : base + ADDR_WIDTH'(cnt);
    cnt_m1    = cnt - 3'd1;
    rdata_nxt = rdata | (32'(ram_data_in) << {cnt_m1[1:0], 3'b000});
  end

`ifdef IO_STALL_EN
  assign stall = io_buffer_full_in && (waddr[17:16] == IO_HIGH_BITS);
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full_in;
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pend_vld        <= 1'b0;
      pend_rw         <= 1'b0;
      pend_addr       <= '0;
      pend_goal       <= '0;
      pend_data       <= '0;
      base            <= '0;
      goal            <= '0;
      cnt             <= '0;
      wdata           <= '0;
      rdata           <= '0;
      lsb_ready_out   <= 1'b0;
      lsb_data_out    <= '0;
      if_ready_out    <= 1'b0;
      if_data_out     <= '0;
      ram_address_out <= '0;
      ram_rw_out      <= 1'b0;
      ram_data_out    <= '0;
    end else begin
      lsb_ready_out <= 1'b0;
      if_ready_out  <= 1'b0;
      ram_rw_out    <= 1'b0;

      // A load arriving with rollback is speculative and never latched.
      if (lsb_request_in && (lsb_rw_in || !rollback_in)) begin
        pend_vld  <= 1'b1;
        pend_rw   <= lsb_rw_in;
        pend_addr <= lsb_address_in;
        pend_goal <= lsb_goal_in;
        pend_data <= lsb_data_in;
      end else if (take_lsb || (pend_vld && !pend_ok)) begin
        pend_vld <= 1'b0;
      end

      case (state)
        LSB_READ, IF_READ: begin
          if (rollback_in) begin
            state           <= IDLE;
            ram_address_out <= '0;
          end else begin
            cnt             <= cnt + 3'd1;
            ram_address_out <= base + ADDR_WIDTH'(cnt + 3'd1);
            if (cnt != 3'd0) rdata <= rdata_nxt;
            if (cnt == goal) begin
              state           <= IDLE;
              ram_address_out <= '0;
              if (state == IF_READ) begin
                if_ready_out <= 1'b1;
                if_data_out  <= rdata_nxt;
              end else begin
                lsb_ready_out <= 1'b1;
                lsb_data_out  <= rdata_nxt;
              end
            end
          end
        end
        LSB_WRITE: begin
          if (cnt == goal) begin
            state           <= IDLE;
            ram_address_out <= '0;
            lsb_ready_out   <= 1'b1;
          end else if (!stall) begin
            ram_rw_out      <= 1'b1;
            ram_address_out <= waddr;
            ram_data_out    <= wbyte;
            cnt             <= cnt + 3'd1;
          end
        end
        default: ram_address_out <= '0;
      endcase

      // Acceptance overrides the completion defaults so back-to-back requests lose no cycle.
      if (take_lsb) begin
        base            <= pend_addr;
        goal            <= pend_goal;
        wdata           <= pend_data;
        rdata           <= '0;
        cnt             <= '0;
        ram_address_out <= pend_addr;
        if (pend_rw) begin
          state <= LSB_WRITE;
          if (!stall) begin
            ram_rw_out   <= 1'b1;
            ram_data_out <= wbyte;
            cnt          <= 3'd1;
          end
        end else begin
          state <= LSB_READ;
        end
      end else if (take_if) begin
        state           <= IF_READ;
        base            <= if_address_in;
        goal            <= 3'd4;
        rdata           <= '0;
        cnt             <= '0;
        ram_address_out <= if_address_in;
      end
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Randomized and directed bench for memory_controller against a byte-array reference model.
module tb_memory_controller;

`ifdef IO_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rollback_in;
  logic        lsb_request_in, lsb_rw_in;
  logic [31:0] lsb_address_in, lsb_data_in;
  logic [2:0]  lsb_goal_in;
  logic        lsb_ready_out;
  logic [31:0] lsb_data_out;
  logic        if_request_in;
  logic [31:0] if_address_in;
  logic        if_ready_out;
  logic [31:0] if_data_out;
  logic [31:0] ram_address_out;
  logic        ram_rw_out;
  logic [7:0]  ram_data_out;
  logic [7:0]  ram_data_in;
  logic        io_buffer_full_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_controller #(.ADDR_WIDTH(32), .IO_HIGH_BITS(2'b11)) dut (
    .clk(clk), .rst(rst), .rollback_in(rollback_in),
    .lsb_request_in(lsb_request_in), .lsb_rw_in(lsb_rw_in), .lsb_address_in(lsb_address_in),
    .lsb_goal_in(lsb_goal_in), .lsb_data_in(lsb_data_in), .lsb_ready_out(lsb_ready_out),
    .lsb_data_out(lsb_data_out), .if_request_in(if_request_in), .if_address_in(if_address_in),
    .if_ready_out(if_ready_out), .if_data_out(if_data_out), .ram_address_out(ram_address_out),
    .ram_rw_out(ram_rw_out), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .io_buffer_full_in(io_buffer_full_in)
  );

  // Byte RAM with one-cycle read latency; addresses alias modulo 1 KiB.
  logic [7:0] mem     [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic       mem_init, pl_en;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 5);
    else if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_rw_out) mem[ram_address_out[9:0]] <= ram_data_out;
    ram_data_in <= mem[ram_address_out[9:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr, input int goal);
    logic [31:0] v = '0;
    for (int k = 0; k < goal; k++) v = v | (32'(ref_mem[10'(addr + 32'(k))]) << (8 * k));
    return v;
  endfunction

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // One LSB request: rb_k = edge offset (from the pulse edge) of a rollback, -1 for none;
  // stall = number of post-pulse edges with io_buffer_full_in high.
  task automatic lsb_op(input string nm, input logic rw, input logic [31:0] addr, input int goal,
                        input logic [31:0] data, input int rb_k, input int stall);
    int          eff, exp_k, got_k, nrdy, nw, chk_k;
    bit          abort;
    logic [31:0] exp_val, prev;
    abort   = !rw && rb_k >= 0 && rb_k <= goal + 2;
    eff     = (STALL_ON && addr[17:16] == 2'b11) ? stall : 0;
    exp_k   = rw ? goal + 1 + eff : goal + 2;
    exp_val = ref_word(addr, goal);
    prev    = lsb_data_out;
    chk_k   = (rb_k < 1) ? 1 : rb_k;
    got_k = -1; nrdy = 0; nw = 0;
    lsb_request_in = 1'b1; lsb_rw_in = rw; lsb_address_in = addr;
    lsb_goal_in = 3'(goal); lsb_data_in = data;
    rollback_in = (rb_k == 0); io_buffer_full_in = 1'b0;
    tick();
    lsb_request_in = 1'b0;
    rollback_in = (rb_k == 1);
    io_buffer_full_in = (stall >= 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      rollback_in = (rb_k == k + 1);
      io_buffer_full_in = (k + 1 <= stall);
      if (lsb_ready_out) begin
        nrdy++;
        if (got_k < 0) got_k = k;
      end
      if (ram_rw_out) begin
        if (nw < 4) begin
          check({nm, "_wr_addr"}, ram_address_out, addr + 32'(nw));
          check({nm, "_wr_data"}, 32'(ram_data_out), (data >> (8 * nw)) & 32'hFF);
          check({nm, "_wr_time"}, k, nw + 1 + eff);
        end
        nw++;
      end
      if (!rw && !abort && k <= goal) check({nm, "_rd_addr"}, ram_address_out, addr + 32'(k - 1));
      if (abort && k == chk_k) check({nm, "_idle_addr"}, ram_address_out, 32'h0);
    end
    rollback_in = 1'b0;
    io_buffer_full_in = 1'b0;
    check({nm, "_nwrites"}, nw, rw ? goal : 0);
    if (abort) begin
      check({nm, "_no_ready"}, nrdy, 0);
      check({nm, "_data_held"}, lsb_data_out, prev);
    end else begin
      check({nm, "_latency"}, got_k, exp_k);
      check({nm, "_one_pulse"}, nrdy, 1);
      if (!rw) begin
        check({nm, "_data"}, lsb_data_out, exp_val);
      end else begin
        for (int k = 0; k < goal; k++) ref_mem[10'(addr + 32'(k))] = 8'(data >> (8 * k));
        for (int k = -1; k <= goal; k++)
          check({nm, "_mem"}, 32'(mem[10'(addr + 32'(k))]), 32'(ref_mem[10'(addr + 32'(k))]));
      end
    end
  endtask

  // One fetch: rb_j = edge index (1 = acceptance edge) carrying a rollback, 0 for none.
  task automatic if_op(input string nm, input logic [31:0] addr, input int rb_j);
    int exp_j, got, n;
    exp_j = (rb_j >= 1 && rb_j <= 6) ? rb_j + 6 : 6;
    got = -1; n = 0;
    if_request_in = 1'b1; if_address_in = addr; rollback_in = (rb_j == 1);
    for (int j = 1; j <= 20; j++) begin
      tick();
      rollback_in = (rb_j == j + 1);
      if (if_ready_out) begin
        n++;
        if (got < 0) got = j;
        if_request_in = 1'b0;
      end
    end
    rollback_in = 1'b0;
    if_request_in = 1'b0;
    check({nm, "_latency"}, got, exp_j);
    check({nm, "_one_pulse"}, n, 1);
    check({nm, "_data"}, if_data_out, ref_word(addr, 4));
  endtask

  initial begin
    int kl, ki, nr;
    rst = 1'b1; rollback_in = 1'b0; lsb_request_in = 1'b0; lsb_rw_in = 1'b0;
    lsb_address_in = '0; lsb_goal_in = '0; lsb_data_in = '0;
    if_request_in = 1'b0; if_address_in = '0; io_buffer_full_in = 1'b0;
    mem_init = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 5);
    repeat (3) tick();
    mem_init = 1'b0;
    check("rst_lsb_ready", 32'(lsb_ready_out), 32'h0);
    check("rst_lsb_data", lsb_data_out, 32'h0);
    check("rst_if_ready", 32'(if_ready_out), 32'h0);
    check("rst_if_data", if_data_out, 32'h0);
    check("rst_ram_addr", ram_address_out, 32'h0);
    check("rst_ram_rw", 32'(ram_rw_out), 32'h0);
    check("rst_ram_data", 32'(ram_data_out), 32'h0);
    rst = 1'b0;
    tick();

    poke(10'h100, 8'h78); poke(10'h101, 8'h56); poke(10'h102, 8'h34); poke(10'h103, 8'h12);
    lsb_op("word_load", 1'b0, 32'h100, 4, 32'h0, -1, 0);
    check("word_load_value", lsb_data_out, 32'h12345678);
    lsb_op("byte_store", 1'b1, 32'h20, 1, 32'hDEADBEEF, -1, 0);
    check("byte_store_value", 32'(mem[10'h20]), 32'hEF);

    // LSB halfword load and IF fetch requested in the same cycle.
    poke(10'h40, 8'hCD); poke(10'h41, 8'hAB);
    if_request_in = 1'b1; if_address_in = 32'h80;
    lsb_request_in = 1'b1; lsb_rw_in = 1'b0; lsb_address_in = 32'h40; lsb_goal_in = 3'd2;
    tick();
    lsb_request_in = 1'b0;
    kl = -1; ki = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (lsb_ready_out && kl < 0) kl = k;
      if (if_ready_out && ki < 0) begin
        ki = k;
        if_request_in = 1'b0;
      end
    end
    if_request_in = 1'b0;
    check("coll_lsb_latency", kl, 4);
    check("coll_lsb_data", lsb_data_out, 32'h0000ABCD);
    check("coll_if_latency", ki, 9);
    check("coll_if_data", if_data_out, ref_word(32'h80, 4));

    lsb_op("rb_load", 1'b0, 32'h100, 4, 32'h0, 3, 0);
    lsb_op("rb_store", 1'b1, 32'h200, 4, 32'hCAFEF00D, 2, 0);
    lsb_op("rb_store_pulse", 1'b1, 32'h210, 2, 32'h00001234, 0, 0);
    lsb_op("rb_load_pulse", 1'b0, 32'h100, 4, 32'h0, 0, 0);
    lsb_op("rb_load_pending", 1'b0, 32'h104, 2, 32'h0, 1, 0);
    lsb_op("wrap_load", 1'b0, 32'hFFFFFFFE, 4, 32'h0, -1, 0);
    lsb_op("half_store", 1'b1, 32'h2FF, 2, 32'h0000BEEF, -1, 0);
    lsb_op("io_store", 1'b1, 32'h00030000, 1, 32'h0000005A, -1, 3);
    lsb_op("plain_store", 1'b1, 32'h00000300, 1, 32'h000000A5, -1, 3);

    if_op("if_plain", 32'h80, 0);
    if_op("if_rb_mid", 32'h84, 3);
    if_op("if_rb_edge", 32'h88, 1);
    if_op("if_rb_last", 32'h8C, 6);

    // Synchronous reset in the middle of a word load.
    lsb_request_in = 1'b1; lsb_rw_in = 1'b0; lsb_address_in = 32'h100; lsb_goal_in = 3'd4;
    tick();
    lsb_request_in = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_lsb_data", lsb_data_out, 32'h0);
    check("midrst_ram_addr", ram_address_out, 32'h0);
    check("midrst_ram_rw", 32'(ram_rw_out), 32'h0);
    nr = 0;
    repeat (12) begin
      tick();
      if (lsb_ready_out) nr++;
    end
    check("midrst_no_ready", nr, 0);

    for (int i = 0; i < 30; i++) begin
      logic rw_r;
      int   g, rb;
      rw_r = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       g = 1;
        1:       g = 2;
        default: g = 4;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      lsb_op($sformatf("rnd%0d", i), rw_r, 32'($urandom_range(0, 1023)), g, $urandom, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Responder for the load/store buffer's memory request interface and for instruction fetch.
- Serializes word, halfword and byte accesses onto the single byte-wide RAM port. The RAM has 1-cycle read latency.
- Arbitrates between the two requesters, with load/store having priority.
- On rollback, cancels speculative reads; committed stores always complete.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- IO_HIGH_BITS, 2'b11, value of address[17:16] that marks the memory-mapped IO region.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rollback_in  in  1  ROB misprediction flush
- lsb_request_in  in  1  one-cycle request pulse from the LSB
- lsb_rw_in  in  1  0 = load, 1 = store
- lsb_address_in  in  ADDR_WIDTH  byte address
- lsb_goal_in  in  3  byte count: 1, 2 or 4
- lsb_data_in  in  32  store data, little-endian
- lsb_ready_out  out  1  one-cycle completion pulse
- lsb_data_out  out  32  load data, zero-extended above goal
- if_request_in  in  1  fetch request, level, held until if_ready_out
- if_address_in  in  ADDR_WIDTH  fetch address
- if_ready_out  out  1  one-cycle completion pulse
- if_data_out  out  32  fetched instruction
- ram_address_out  out  ADDR_WIDTH  RAM byte address
- ram_rw_out  out  1  1 = write
- ram_data_out  out  8  RAM write byte
- ram_data_in  in  8  RAM read byte, valid 1 cycle after its address
- io_buffer_full_in  in  1  UART TX buffer full

Behaviour:
- All outputs are registered.
- Reset values:
  - outputs: all 0
  - state: IDLE
  - pending flag: 0
  - byte counter: 0
- Pending latch:
  - lsb_request_in with its address, rw, goal and data is captured into a pending register on any cycle, busy or not.
  - The LSB never has more than one outstanding request.
  - A pulse arriving while a previous pending entry is still unserved is a protocol error. Overwrite the entry; no recovery is required.
- States: IDLE, LSB_READ, LSB_WRITE, IF_READ.
- IDLE:
  - If pending is set: go to LSB_WRITE or LSB_READ and clear pending.
  - Else if if_request_in is high: go to IF_READ with n = 4.
  - Else: drive ram_rw_out = 0 and ram_address_out = 0.
- Byte sequencing:
  - On the acceptance edge E, the byte 0 address is registered. Byte k's address is driven during cycle E+1+k.
  - Reads: RAM data for byte k is sampled at edge E+2+k into bits [8k+7:8k]. Completion is at edge E+n+1, so ready is high during cycle E+n+2.
  - Writes: ram_rw_out = 1 and ram_data_out = lsb_data_in[8k+7:8k] at address+k during cycle E+1+k. ready pulses during cycle E+n+1.
  - The state returns to IDLE together with the ready pulse. A new request may be accepted on that same edge.
- Data formatting:
  - Load data is zero-extended above goal bytes. The LSB performs sign extension.
  - if_data_out and lsb_data_out hold their value until the next completion.
- Address arithmetic: address + k, modulo 2^ADDR_WIDTH. No alignment check.
- Rollback (rollback_in high on an edge):
  - In LSB_READ or IF_READ: go to IDLE at once with no ready pulse, and force ram_rw_out = 0.
  - A pending load is discarded.
  - A pending store and an in-progress LSB_WRITE are unaffected and must finish.
  - A lsb_request_in pulse in the same cycle as rollback_in is dropped if it is a load and kept if it is a store.
  - if_request_in is ignored on the rollback edge.
- Priority collision: if pending is set and if_request_in is high in IDLE, the LSB is served. IF waits; its request stays high.
- rst mid-operation: return to IDLE immediately, drop everything and emit no ready pulse.

Optional Feature:
- Macro: IO_STALL_EN.
- Defined:
  - Before each write byte to an address with [17:16] == IO_HIGH_BITS, the controller waits while io_buffer_full_in is high.
  - While waiting, ram_rw_out = 0 and the byte counter holds.
  - Ready latency grows by the number of stall cycles.
- Undefined: io_buffer_full_in is ignored and write timing is fixed.

Test Plan:
- Word load:
  - Stimulus: LSB load, addr 0x100, goal 4; RAM bytes 0x78, 0x56, 0x34, 0x12.
  - Required: lsb_data_out = 0x12345678, lsb_ready_out pulses once during cycle E+6, addresses 0x100..0x103 in order.
- Byte store:
  - Stimulus: LSB store, goal 1, data 0xDEADBEEF, addr 0x20.
  - Required: one write cycle with address 0x20, data 0xEF, rw = 1; ready during cycle E+2; RAM word unchanged elsewhere.
- Collision:
  - Stimulus: if_request_in high and an LSB halfword load pulse in the same cycle.
  - Required: the LSB is served first and returns 0x0000ABCD for RAM bytes CD, AB; the IF fetch starts on the ready edge and if_ready_out follows 6 cycles later.
- Rollback during load:
  - Stimulus: rollback_in at cycle E+2 of a word load.
  - Required: no lsb_ready_out, state IDLE next cycle, ram_rw_out stays 0.
- Rollback during store:
  - Stimulus: rollback_in during a word store to 0x200.
  - Required: all 4 bytes written; ready pulse occurs at E+5 as normal.
- IO stall (IO_STALL_EN defined):
  - Stimulus: byte store to 0x30000 with io_buffer_full_in high for 3 cycles.
  - Required: write occurs 3 cycles late, ready during cycle E+5.
